carry_skip_adder: RTL and testbench
===================================

// Module: carry_skip_adder
// PURPOSE
//  Registered WIDTH-bit carry-skip (carry-bypass) adder: sum/carry = a + b + cin.
//  Operands are split into BLOCK-bit ripple groups; a group whose bits all propagate
//  forwards its carry-in directly to the next group via a skip mux.
//  Sits in datapath as a drop-in adder with one cycle of latency.
// PARAMETERS
//  WIDTH  4  operand/sum width in bits; must be a multiple of BLOCK
//  BLOCK  4  bits per ripple group; number of groups = WIDTH/BLOCK
// PORTS
//  clk    in   1      rising-edge clock
//  rst    in   1      asynchronous, active-high reset
//  sum    out  WIDTH  registered sum bits, (a+b+cin) mod 2^WIDTH
//  carry  out  1      registered carry-out, bit WIDTH of a+b+cin
//  a      in   WIDTH  operand A, unsigned
//  b      in   WIDTH  operand B, unsigned
//  cin    in   1      carry-in
//  One clock; reset is asynchronous and active-high.
// BEHAVIOUR
//  - rst=1 (asynchronous, any time): sum=0, carry=0 immediately; held until rst=0.
//  - Each rising clk with rst=0: {carry,sum} <= a + b + cin. Latency 1 cycle.
//    New operands are accepted every cycle; no handshake and no stall.
//  - Unsigned arithmetic. Full result width is WIDTH+1. The result is exact for
//    every input combination, including all-ones operands with cin=1.
//  - Per group g, with carry-in c_g (c_0 = cin):
//      p_i = a_i ^ b_i
//      g_i = a_i & b_i
//      s_i = p_i ^ c_i
//      ripple: c_{i+1} = g_i | (p_i & c_i)
//      P_g = &p over the group
//      c_{g+1} = P_g ? c_g : ripple_cout_g
//  - The skip mux must select the same value as ripple would. It exists only to
//    shorten the carry path; it must never change the result.
//  - Reset released mid-stream: the first capture is on the first rising clk after
//    rst falls. No stale value is produced.
//  - X on inputs is not sanitised; outputs follow the arithmetic.
//  - Elaboration check: WIDTH % BLOCK != 0 is a fatal elaboration error.
// STRUCTURE
//  - Sub-module csa_block:
//    - combinational BLOCK-bit ripple adder with group propagate P and skip mux;
//    - ports a, b, cin, sum, cout.
//  - Top level:
//    - generate-instantiates WIDTH/BLOCK csa_block in a chain;
//    - registers {carry, sum} in one always block with async reset.
//  - Shared package carry_skip_pkg holds:
//    - default constants CSA_WIDTH=4 and CSA_BLOCK=4;
//    - a localparam function for the group count.
// TESTING (defaults WIDTH=4, BLOCK=4; check one clk after apply)
//  1 a=1100 b=0001 cin=0 -> sum=1101 carry=0; a=0110 b=0010 cin=0 -> sum=1000 carry=0
//  2 a=0101 b=1011 cin=1 -> sum=0001 carry=1; a=1110 b=0111 cin=1 -> sum=0110 carry=1
//  3 a=1101 b=0110 cin=1 -> sum=0100 carry=1; a=1111 b=0010 cin=1 -> sum=0010 carry=1
//  4 Skip path: a=0101 b=1010 cin=1 -> sum=0000 carry=1; same with cin=0 -> 1111, 0
//  5 Assert rst between clks after loading a=1111 b=1111 cin=1:
//    outputs go to 0 immediately, without waiting for clk;
//    first clk after release gives sum=1111 carry=1
//  6 Exhaustive 2^9 sweep at WIDTH=4, plus a random sweep at WIDTH=16 BLOCK=4;
//    every result compared against the behavioural a+b+cin one cycle later

Source files
------------

// File: rtl/carry_skip_pkg.sv
// Shared constants and helpers for the registered carry-skip adder.
package carry_skip_pkg;

  localparam int CSA_WIDTH = 4;
  localparam int CSA_BLOCK = 4;

  function automatic int csa_groups(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/carry_skip_adder_csa_block.sv
// One BLOCK-bit ripple group with group propagate and a carry-skip mux.
module csa_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK-1:0] p;
  logic [BLOCK-1:0] g;
  logic [BLOCK:0]   c;
  logic             grp_p;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum   = p ^ c[BLOCK-1:0];
  assign grp_p = &p;
  // When every bit propagates, the ripple carry-out equals cin, so the
  // bypass only shortens the path and never changes the value.
  assign cout  = grp_p ? cin : c[BLOCK];

endmodule

// File: rtl/carry_skip_adder.sv
// Registered WIDTH-bit carry-skip adder: {carry,sum} <= a + b + cin, one cycle latency.
module carry_skip_adder
  import carry_skip_pkg::*;
#(
  parameter int WIDTH = CSA_WIDTH,
  parameter int BLOCK = CSA_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int NGROUPS = csa_groups(WIDTH, BLOCK);

  if ((WIDTH % BLOCK) != 0) begin : g_bad_width
    $fatal(1, "carry_skip_adder: WIDTH must be a multiple of BLOCK");
  end

  logic [NGROUPS:0] gc;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;

  assign gc[0] = cin;

  for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_grp
    csa_block #(.BLOCK(BLOCK)) u_blk (
      .a    (a[gi*BLOCK +: BLOCK]),
      .b    (b[gi*BLOCK +: BLOCK]),
      .cin  (gc[gi]),
      .sum  (sum_d[gi*BLOCK +: BLOCK]),
      .cout (gc[gi+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= gc[NGROUPS];
    end
  end

  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_carry_skip_adder.sv
// Self-checking bench for carry_skip_adder at 4/4 and 16/4 geometries.
module tb_carry_skip_adder;

  logic        clk;
  logic        rst;
  logic [3:0]  a4, b4, sum4;
  logic        cin4, carry4;
  logic [15:0] a16, b16, sum16;
  logic        cin16, carry16;

  int errors = 0;
  int checks = 0;

  logic [4:0]  exp4_q[$];
  logic [16:0] exp16_q[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_sum;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[8];

  carry_skip_adder #(.WIDTH(4), .BLOCK(4)) dut4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4), .sum(sum4), .carry(carry4)
  );

  carry_skip_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16), .sum(sum16), .carry(carry16)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic c);
    a4 = a; b4 = b; cin4 = c;
  endtask

  // Behavioural reference: plain integer addition at full width.
  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic c);
    return 5'(a) + 5'(b) + 5'(c);
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  initial begin
    rst = 1'b1;
    drive4(4'h0, 4'h0, 1'b0);
    a16 = '0; b16 = '0; cin16 = 1'b0;

    vecs[0] = '{4'b1100, 4'b0001, 1'b0, 4'b1101, 1'b0};
    vecs[1] = '{4'b0110, 4'b0010, 1'b0, 4'b1000, 1'b0};
    vecs[2] = '{4'b0101, 4'b1011, 1'b1, 4'b0001, 1'b1};
    vecs[3] = '{4'b1110, 4'b0111, 1'b1, 4'b0110, 1'b1};
    vecs[4] = '{4'b1101, 4'b0110, 1'b1, 4'b0100, 1'b1};
    vecs[5] = '{4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1};
    vecs[6] = '{4'b0101, 4'b1010, 1'b1, 4'b0000, 1'b1};
    vecs[7] = '{4'b0101, 4'b1010, 1'b0, 4'b1111, 1'b0};

    #2;
    check("reset_sum4", 32'(sum4), 32'h0);
    check("reset_carry4", 32'(carry4), 32'h0);
    check("reset_sum16", 32'(sum16), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      drive4(vecs[i].a, vecs[i].b, vecs[i].cin);
      @(negedge clk);
      check($sformatf("vec%0d_sum", i), 32'(sum4), 32'(vecs[i].exp_sum));
      check($sformatf("vec%0d_carry", i), 32'(carry4), 32'(vecs[i].exp_carry));
    end

    // Asynchronous reset between clocks, then release mid-cycle
    drive4(4'hf, 4'hf, 1'b1);
    @(negedge clk);
    check("preload_sum", 32'(sum4), 32'hf);
    check("preload_carry", 32'(carry4), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_sum", 32'(sum4), 32'h0);
    check("async_rst_carry", 32'(carry4), 32'h0);
    @(negedge clk);
    check("held_rst_sum", 32'(sum4), 32'h0);
    check("held_rst_carry", 32'(carry4), 32'h0);
    #2 rst = 1'b0;
    #1;
    check("released_no_stale", 32'(sum4), 32'h0);
    @(negedge clk);
    check("post_rst_sum", 32'(sum4), 32'hf);
    check("post_rst_carry", 32'(carry4), 32'h1);

    // Exhaustive streaming sweep at WIDTH=4, one new operand set per cycle
    for (int k = 0; k < 512; k++) begin
      logic [3:0] ta, tb;
      logic tc;
      ta = 4'(k >> 5);
      tb = 4'(k >> 1);
      tc = k[0];
      drive4(ta, tb, tc);
      exp4_q.push_back(ref4(ta, tb, tc));
      @(negedge clk);
      check("sweep4", 32'({carry4, sum4}), 32'(exp4_q.pop_front()));
    end

    // Random back-to-back sweep at WIDTH=16
    for (int k = 0; k < 2000; k++) begin
      if (exp16_q.size() != 0)
        check("rand16", 32'({carry16, sum16}), 32'(exp16_q.pop_front()));
      case ($urandom_range(0, 3))
        0: begin a16 = 16'hffff; b16 = 16'($urandom); end
        1: begin a16 = 16'($urandom); b16 = ~a16; end
        default: begin a16 = 16'($urandom); b16 = 16'($urandom); end
      endcase
      cin16 = 1'($urandom_range(0, 1));
      exp16_q.push_back(ref16(a16, b16, cin16));
      @(negedge clk);
    end
    check("rand16_last", 32'({carry16, sum16}), 32'(exp16_q.pop_front()));

    // All-ones corner at WIDTH=16
    a16 = 16'hffff; b16 = 16'hffff; cin16 = 1'b1;
    @(negedge clk);
    check("ones16", 32'({carry16, sum16}), 32'h1ffff);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
